// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid-buffered pipeline register stage
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous kill of all held beats; same-cycle input is dropped
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (registered, no path from out_ready)
//   in_ctrl    upstream control payload
//   in_data    upstream data payload
//   out_valid  downstream beat present
//   out_ready  downstream accepts the beat
//   out_ctrl   control payload from the main register
//   out_data   data payload from the main register
//   occupancy  held beats 0..2
//   stall_cnt  saturating count of cycles with out_valid & !out_ready

module pipe_skid_stage #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16,
    parameter bit ZERO_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding doubles as the occupancy count; the valid bits of the
    // main and skid registers are implied by the state (main valid when not
    // EMPTY, skid valid when FULL).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            stateQ, stateD;
    logic [CTRL_W-1:0] mainCtrl, mainCtrlD, skidCtrl, skidCtrlD;
    logic [DATA_W-1:0] mainData, mainDataD, skidData, skidDataD;
    logic [CNT_W-1:0]  stallCnt;
    logic              inXfer, outXfer;

    assign in_ready  = (stateQ != FULL);
    assign out_valid = (stateQ != EMPTY);
    assign out_ctrl  = mainCtrl;
    assign out_data  = mainData;
    assign occupancy = stateQ;
    assign stall_cnt = stallCnt;

    assign inXfer  = in_valid & in_ready;
    assign outXfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ   <= EMPTY;
            mainCtrl <= '0;
            mainData <= '0;
            skidCtrl <= '0;
            skidData <= '0;
        end else begin
            stateQ   <= stateD;
            mainCtrl <= mainCtrlD;
            mainData <= mainDataD;
            skidCtrl <= skidCtrlD;
            skidData <= skidDataD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        mainCtrlD = mainCtrl;
        mainDataD = mainData;
        skidCtrlD = skidCtrl;
        skidDataD = skidData;

        if (flush) begin
            // Flush wins over every transfer; an output handshake in this
            // cycle has already been consumed downstream, so nothing is kept.
            stateD    = EMPTY;
            mainCtrlD = '0;
            skidCtrlD = '0;
            if (ZERO_DATA) begin
                mainDataD = '0;
                skidDataD = '0;
            end
        end else begin
            case (stateQ)
                EMPTY: begin
                    if (inXfer) begin
                        mainCtrlD = in_ctrl;
                        mainDataD = in_data;
                        stateD    = ONE;
                    end
                end
                ONE: begin
                    if (inXfer && outXfer) begin
                        mainCtrlD = in_ctrl;
                        mainDataD = in_data;
                    end else if (inXfer) begin
                        skidCtrlD = in_ctrl;
                        skidDataD = in_data;
                        stateD    = FULL;
                    end else if (outXfer) begin
                        mainCtrlD = '0;
                        if (ZERO_DATA) begin
                            mainDataD = '0;
                        end
                        stateD = EMPTY;
                    end
                end
                FULL: begin
                    if (outXfer) begin
                        mainCtrlD = skidCtrl;
                        mainDataD = skidData;
                        skidCtrlD = '0;
                        if (ZERO_DATA) begin
                            skidDataD = '0;
                        end
                        stateD = ONE;
                    end
                end
                default: begin
                    stateD    = EMPTY;
                    mainCtrlD = '0;
                    skidCtrlD = '0;
                    mainDataD = '0;
                    skidDataD = '0;
                end
            endcase
        end
    end

    // Stall counter ignores flush so it reflects true downstream backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (out_valid && !out_ready && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage

module tb_pipe_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [7:0]  inCtrl;
    logic [31:0] inData;
    logic        outValid;
    logic        outReady;
    logic [7:0]  outCtrl;
    logic [31:0] outData;
    logic [1:0]  occupancy;
    logic [15:0] stallCnt;

    logic        bFlush;
    logic        bInValid;
    logic        bInReady;
    logic [7:0]  bInCtrl;
    logic [31:0] bInData;
    logic        bOutValid;
    logic        bOutReady;
    logic [7:0]  bOutCtrl;
    logic [31:0] bOutData;
    logic [1:0]  bOccupancy;
    logic [3:0]  bStallCnt;

    int checks   = 0;
    int failures = 0;

    logic [39:0] expQ[$];

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(16), .ZERO_DATA(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_ctrl   (inCtrl),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_ctrl  (outCtrl),
        .out_data  (outData),
        .occupancy (occupancy),
        .stall_cnt (stallCnt)
    );

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(4), .ZERO_DATA(1'b0)) dutB (
        .clk       (clk),
        .rst       (rst),
        .flush     (bFlush),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .in_ctrl   (bInCtrl),
        .in_data   (bInData),
        .out_valid (bOutValid),
        .out_ready (bOutReady),
        .out_ctrl  (bOutCtrl),
        .out_data  (bOutData),
        .occupancy (bOccupancy),
        .stall_cnt (bStallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ctrlOf(input logic [31:0] d);
        return d[7:0] ^ 8'hC3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the beat until the stage accepts it; the expected output is
    // queued at the moment of acceptance.
    task automatic sendBeat(input logic [31:0] d);
        bit done;
        done    = 1'b0;
        inValid = 1'b1;
        inData  = d;
        inCtrl  = ctrlOf(d);
        for (int k = 0; k < 20 && !done; k++) begin
            if (inReady) begin
                expQ.push_back({ctrlOf(d), d});
                done = 1'b1;
            end
            step();
        end
        if (!done) check("send_accept_timeout", 64'd0, 64'd1);
    endtask

    // Output-side scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (rst && outValid && outReady) begin
            if (expQ.size() == 0) begin
                check("unexpected_beat", {24'd0, outCtrl, outData}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = expQ.pop_front();
                check("out_beat", {24'd0, outCtrl, outData}, {24'd0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; inValid = 1'b0; inCtrl = '0; inData = '0; outReady = 1'b0;
        bFlush = 1'b0; bInValid = 1'b0; bInCtrl = '0; bInData = '0; bOutReady = 1'b0;
        #3;
        check("rst_out_valid", outValid, 0);
        check("rst_in_ready", inReady, 1);
        check("rst_occupancy", occupancy, 0);
        check("rst_out_ctrl", outCtrl, 0);
        check("rst_out_data", outData, 0);
        check("rst_stall_cnt", stallCnt, 0);
        #7 rst = 1'b1;
        #1;

        // Streaming at full rate.
        outReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            sendBeat(i);
            check("stream_occ", occupancy, 1);
            check("stream_valid", outValid, 1);
            check("stream_data", outData, i);
        end
        inValid = 1'b0;
        step();
        check("stream_drain_occ", occupancy, 0);
        check("stream_stall", stallCnt, 0);

        // Backpressure: 5 and 6 fill the stage, 7 waits upstream.
        outReady = 1'b0;
        sendBeat(5);
        sendBeat(6);
        check("bp_occ_full", occupancy, 2);
        check("bp_in_ready", inReady, 0);
        inData = 7; inCtrl = ctrlOf(7);
        step(); step(); step();
        check("bp_hold_data", outData, 5);
        check("bp_stall_cnt", stallCnt, 4);
        outReady = 1'b1;
        sendBeat(7);
        inValid = 1'b0;
        step();
        check("bp_drain_occ", occupancy, 0);
        check("bp_stall_after", stallCnt, 4);

        // Flush while FULL with a pending input beat of 9.
        outReady = 1'b0;
        sendBeat(32'h11);
        sendBeat(32'h12);
        check("fl_full_occ", occupancy, 2);
        inData = 9; inCtrl = ctrlOf(9); flush = 1'b1;
        step();
        flush = 1'b0; inValid = 1'b0;
        expQ.delete();
        check("fl_occ", occupancy, 0);
        check("fl_out_valid", outValid, 0);
        check("fl_out_ctrl", outCtrl, 0);
        check("fl_out_data", outData, 0);
        check("fl_in_ready", inReady, 1);
        check("fl_stall_cnt", stallCnt, 6);

        // Flush in ONE with in_ready=1: 0x21 is consumed, 9 is discarded.
        outReady = 1'b1;
        sendBeat(32'h21);
        inData = 9; inCtrl = ctrlOf(9); flush = 1'b1;
        step();
        flush = 1'b0; inValid = 1'b0;
        check("fl1_queue_empty", expQ.size(), 0);
        expQ.delete();
        check("fl1_occ", occupancy, 0);
        step(); step();
        check("fl1_no_nine", outValid, 0);

        // Asynchronous reset between edges while FULL.
        outReady = 1'b0;
        sendBeat(32'h31);
        sendBeat(32'h32);
        inValid = 1'b0;
        check("ar_full_occ", occupancy, 2);
        #2 rst = 1'b0;
        #1;
        check("ar_out_valid", outValid, 0);
        check("ar_in_ready", inReady, 1);
        check("ar_occ", occupancy, 0);
        check("ar_out_data", outData, 0);
        check("ar_out_ctrl", outCtrl, 0);
        check("ar_stall_cnt", stallCnt, 0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b1;
        outReady = 1'b1;
        sendBeat(32'h41);
        check("ar_first_valid", outValid, 1);
        check("ar_first_data", outData, 32'h41);
        inValid = 1'b0;
        step();
        check("ar_drained", occupancy, 0);

        // ZERO_DATA=0 drain on the second instance.
        bOutReady = 1'b1;
        bInValid = 1'b1; bInData = 32'hA5; bInCtrl = 8'h3C;
        step();
        bInValid = 1'b0;
        check("zd_valid", bOutValid, 1);
        check("zd_data", bOutData, 32'hA5);
        check("zd_ctrl", bOutCtrl, 8'h3C);
        step();
        check("zd_drain_valid", bOutValid, 0);
        check("zd_drain_ctrl", bOutCtrl, 0);
        check("zd_drain_data", bOutData, 32'hA5);

        // Saturation of a 4-bit stall counter.
        bOutReady = 1'b0;
        bInValid = 1'b1; bInData = 32'h1; bInCtrl = 8'h01;
        step();
        bInValid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("sat_mid", bStallCnt, 10);
        for (int i = 0; i < 10; i++) step();
        check("sat_stick", bStallCnt, 15);

        check("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
- REQ-001: Parameter DATA_W, default 32, width of the datapath payload (ALU result, operands, constant).
- REQ-002: Parameter CTRL_W, default 8, width of the control payload (write enables, load/store flags, branch code).
- REQ-003: Parameter CNT_W, default 16, width of the stall performance counter.
- REQ-004: Parameter ZERO_DATA, default 1; when 1, data is cleared along with control on bubble or flush; when 0, only control is cleared.
- REQ-005: clk  input  1  clock; all state updates on rising edge.
- REQ-006: rst  input  1  reset, asynchronous, active-low.
- REQ-007: flush  input  1  synchronous kill of all held beats (hazard/branch squash).
- REQ-008: in_valid  input  1  upstream beat present.
- REQ-009: in_ready  output  1  stage can accept a beat this cycle.
- REQ-010: in_ctrl  input  CTRL_W  upstream control payload.
- REQ-011: in_data  input  DATA_W  upstream data payload.
- REQ-012: out_valid  output  1  downstream beat present.
- REQ-013: out_ready  input  1  downstream accepts the beat this cycle.
- REQ-014: out_ctrl  output  CTRL_W  registered control payload.
- REQ-015: out_data  output  DATA_W  registered data payload.
- REQ-016: occupancy  output  2  number of held beats, 0..2.
- REQ-017: stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
- REQ-018: Storage SHALL be a main register (drives outputs) and a skid register, each holding {ctrl, data, valid}.
- REQ-019: The state machine SHALL have states EMPTY (occupancy 0), ONE (1), FULL (2).
- REQ-020: in_ready SHALL equal (state != FULL), derived from registered state only, with no combinational path from out_ready.
- REQ-021: out_valid SHALL equal (state != EMPTY); out_ctrl/out_data SHALL come from the main register only.
- REQ-022: A transfer SHALL occur on the input side when in_valid & in_ready, and on the output side when out_valid & out_ready.
- REQ-023: EMPTY: input transfer -> main<=in, go to ONE; otherwise stay EMPTY.
- REQ-024: ONE: input and output transfer -> main<=in, stay ONE; input transfer only -> skid<=in, go to FULL; output transfer only -> go to EMPTY; neither -> hold.
- REQ-025: FULL: output transfer -> main<=skid, go to ONE; otherwise hold; no input transfer is possible.
- REQ-026: Latency SHALL be 1 cycle from input transfer to out_valid; sustained throughput SHALL be 1 beat/cycle while out_ready=1.
- REQ-027: Beat order SHALL be preserved; no beat shall be dropped or duplicated except by flush.
- REQ-028: On entering EMPTY, main ctrl SHALL be zero; main data SHALL also be zero if ZERO_DATA=1, else it holds its last value.
- REQ-029: On leaving FULL, skid ctrl SHALL be zero (skid data per ZERO_DATA).
- REQ-030: flush=1 SHALL take priority over all transfers: next state EMPTY, both ctrl fields zero (data per ZERO_DATA), and any same-cycle input beat discarded even if in_ready=1.
- REQ-031: An output transfer in a flush cycle SHALL still count as consumed downstream; the stage SHALL not retain the beat.
- REQ-032: stall_cnt SHALL increment by 1 each cycle with out_valid & !out_ready, saturate at 2^CNT_W-1, and be unaffected by flush.
- REQ-033: occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
- REQ-034: With rst low, asynchronously: state EMPTY, all payload registers 0, stall_cnt 0, out_valid 0, in_ready 1, occupancy 0.
- REQ-035: Reset asserted mid-operation SHALL discard all held beats; the first rising edge after release SHALL behave as EMPTY.

Verification
- REQ-036: Streaming: out_ready=1, beats D=1..8 on consecutive cycles -> out_data 1..8 each one cycle later, occupancy never >1, stall_cnt 0.
- REQ-037: Backpressure: in ONE with D=5, out_ready=0, push D=6 -> FULL, in_ready=0, D=7 held upstream; release out_ready -> 5, 6, 7 in order; stall_cnt = number of stalled cycles.
- REQ-038: Flush in FULL with in_valid=1 D=9 -> next cycle occupancy 0, out_valid 0, out_ctrl 0, D=9 never appears.
- REQ-039: ZERO_DATA=0 drain: last beat D=0xA5 consumed -> out_ctrl 0, out_data stays 0xA5, out_valid 0.
- REQ-040: Saturation: CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt sticks at 15.
- REQ-041: Async reset asserted between clock edges while FULL -> outputs zero immediately, in_ready 1; first beat after release passes with 1-cycle latency.
